conv_window_buffer: RTL and testbench
=====================================

# conv_window_buffer

Streaming 5x5 window generator that sits directly upstream of the 25-tap Float8 convolution stage. It accepts one Float8 pixel per cycle in raster order (row-major, 28x28 image by default). It keeps the last four image rows plus five pixels in a delay line. Whenever a full 5x5 valid-region window is available, it presents all 25 taps in parallel, with a valid/ready handshake, to the convolution datapath's two 200-bit operand buses (image side).

## Interface
- IMG_W, 28: image width in pixels (≥ 5)
- IMG_H, 28: image height in pixels (≥ 5)
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- clr  input  1  synchronous frame restart pulse
- in_valid  input  1  pixel_in valid
- in_ready  output  1  block can accept pixel this cycle
- pixel_in  input  8  Float8 pixel; opaque, never interpreted
- win_valid  output  1  win_data holds a complete window
- win_ready  input  1  downstream consumes window this cycle
- win_data  output  200  25 taps; tap i = bits [8i+7:8i], i = r*5+c; r=0 is the oldest (top) row, c=0 is the oldest (left) column; tap 24 is the newest pixel
- win_last  output  1  only when CONV_WIN_LAST_EN is defined (see Configuration)

## Operation
- Delay line is 4*IMG_W+5 bytes and shifts by one on each accept (in_valid && in_ready). Tap (r,c) reads position (4-r)*IMG_W+(4-c) counted back from the newest pixel.
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1 count accepted pixels.
  - col wraps to 0 after IMG_W-1 and row increments.
  - After (IMG_H-1, IMG_W-1) both wrap to 0. A new frame follows with no gap and no clr needed.
- Window is complete when the accepted pixel has row ≥ 4 and col ≥ 4. No windows straddle a row boundary. Windows per frame = (IMG_W-4)*(IMG_H-4) = 576 by default.
- Handshake:
  - in_ready = !win_valid || win_ready (combinational).
  - win_valid sets on the accept that completes a window.
  - win_valid clears when win_ready is high and that same cycle's accept (if any) does not complete a window.
  - While win_valid && !win_ready, win_data is held stable and no pixel is accepted.
- clr resets row, col and win_valid to 0. The delay line is not cleared.
  - clr overrides an accept in the same cycle. That pixel is dropped and in_ready is forced low during clr.
  - The next window appears only after 4*IMG_W+5 further accepted pixels.
- Reset values: win_valid=0, win_data=0 (delay line zeroed), in_ready=1, row=col=0, win_last=0.
- Reset mid-frame aborts the frame. The first accepted pixel after reset is treated as (0,0).

## Timing
- Latency is 1 cycle: win_valid and win_data update on the clock edge that accepts the completing pixel.
- Sustained throughput is 1 pixel/cycle when win_ready is held high.
- There is no combinational path from pixel_in to win_data. There is a combinational path from win_ready to in_ready.
- Line-boundary cycles (col 0..3) and rows 0..3 accept pixels with win_valid low, once the previous window has been consumed.

## Configuration
- CONV_WIN_LAST_EN defined: adds the win_last output. It is high together with win_valid for the final window of a frame (completing pixel at row IMG_H-1, col IMG_W-1) and is held with win_data under backpressure.
- CONV_WIN_LAST_EN undefined: the port and its logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package holds: KERNEL_DIM=5, KERNEL_TAPS=25, FLOAT8_W=8, and the derived WIN_BUS_W=200.
- One sub-module, conv_line_shift: a parameterised shift-enable delay line that exposes the 25 tap positions. The top level owns the counters, handshake and clr.

## Test plan
- Reset mid-stream, then release: win_valid=0, in_ready=1, win_data=0; first window requires 117 further accepts.
- Frame 28x28 with pixel = (row*28+col) mod 256 and win_ready=1:
  - Exactly 576 windows.
  - First window on pixel index 116: tap0=0x00, tap4=0x04, tap20=0x70, tap24=0x74.
- Backpressure: win_ready=0 for 10 cycles after the first window: in_ready=0, win_data unchanged. After release, the following window equals the pixel (4,5) window with no pixel lost.
- Row boundary: window at (4,27) is produced; pixels (5,0)..(5,3) give no window; next window is on (5,4) with tap24=(5*28+4) mod 256=0x90.
- clr asserted together with in_valid mid-frame: that pixel is dropped and the counters restart. Back-to-back frames without clr produce 576 windows each.
- With CONV_WIN_LAST_EN: win_last is high only with the 576th window, and is held under a 3-cycle win_ready=0 stall.

Source files
------------

// File: rtl/conv_window_buffer_pkg.sv
// conv_window_buffer_pkg
// Shared constants for the 5x5 Float8 window generator and its delay line.
//   KERNEL_DIM  : window edge length (5)
//   KERNEL_TAPS : taps per window (25)
//   FLOAT8_W    : bits per pixel (8)
//   WIN_BUS_W   : width of the parallel tap bus (200)
// tap_offset() gives the delay-line position (counted back from the newest
// pixel) that feeds window tap (r, c).
package conv_window_buffer_pkg;

    localparam int KERNEL_DIM  = 5;
    localparam int KERNEL_TAPS = KERNEL_DIM * KERNEL_DIM;
    localparam int FLOAT8_W    = 8;
    localparam int WIN_BUS_W   = KERNEL_TAPS * FLOAT8_W;

    function automatic int tap_offset(input int r, input int c, input int img_w);
        return (KERNEL_DIM - 1 - r) * img_w + (KERNEL_DIM - 1 - c);
    endfunction

endpackage

// File: rtl/conv_line_shift.sv
// conv_line_shift
// Shift-enabled delay line of (KERNEL_DIM-1)*IMG_W + KERNEL_DIM pixels that
// exposes the 25 window tap positions as one flat bus.
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset, zeroes the whole line
//   shift_en : advance the line by one pixel this cycle
//   pixel    : pixel entering the line (position 0 = newest)
//   taps     : tap i = r*KERNEL_DIM+c at bits [8i+7:8i]; r=0/c=0 is the
//              oldest row/column, tap 24 is the newest pixel
module conv_line_shift
    import conv_window_buffer_pkg::*;
#(
    parameter int IMG_W = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_en,
    input  logic [FLOAT8_W-1:0]  pixel,
    output logic [WIN_BUS_W-1:0] taps
);

    localparam int DEPTH = (KERNEL_DIM - 1) * IMG_W + KERNEL_DIM;

    logic [FLOAT8_W-1:0] line [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) line[i] <= '0;
        end else if (shift_en) begin
            line[0] <= pixel;
            for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
        end
    end

    // Taps come straight from registers, so pixel never reaches taps combinationally.
    for (genvar r = 0; r < KERNEL_DIM; r++) begin : g_row
        for (genvar c = 0; c < KERNEL_DIM; c++) begin : g_col
            assign taps[(r*KERNEL_DIM + c)*FLOAT8_W +: FLOAT8_W] = line[tap_offset(r, c, IMG_W)];
        end
    end

endmodule

// File: rtl/conv_window_buffer.sv
// conv_window_buffer
// Streaming 5x5 window generator. Accepts one Float8 pixel per cycle in
// raster order and presents every complete valid-region window as 25
// parallel taps with a valid/ready handshake.
// Optional feature macro: CONV_WIN_LAST_EN adds win_last, flagging the final
// window of each frame.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   clr       : synchronous frame restart (row/col/win_valid to 0)
//   in_valid  : pixel_in valid
//   in_ready  : pixel can be accepted this cycle
//   pixel_in  : Float8 pixel, opaque
//   win_valid : win_data holds a complete window
//   win_ready : downstream consumes the window this cycle
//   win_data  : 25 taps, tap i = bits [8i+7:8i], i = r*5+c
//   win_last  : (CONV_WIN_LAST_EN only) window is the last of the frame
module conv_window_buffer
    import conv_window_buffer_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FLOAT8_W-1:0]  pixel_in,
    output logic                 win_valid,
    input  logic                 win_ready,
    output logic [WIN_BUS_W-1:0] win_data
`ifdef CONV_WIN_LAST_EN
    ,
    output logic                 win_last
`endif
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_MAX   = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(KERNEL_DIM - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(KERNEL_DIM - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             accept;
    logic             at_window;

    // A held window blocks intake; clr also blocks it so the pixel is dropped.
    assign in_ready  = !clr && (!win_valid || win_ready);
    assign accept    = in_valid && in_ready;
    // The pixel at (row, col) is the bottom-right corner of a full window.
    assign at_window = (row >= ROW_FIRST) && (col >= COL_FIRST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
        end else if (clr) begin
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
        end else begin
            if (accept) begin
                if (col == COL_MAX) begin
                    col <= '0;
                    row <= (row == ROW_MAX) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (accept && at_window) begin
                win_valid <= 1'b1;
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

`ifdef CONV_WIN_LAST_EN
    logic at_frame_end;
    assign at_frame_end = (row == ROW_MAX) && (col == COL_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_last <= 1'b0;
        end else if (clr) begin
            win_last <= 1'b0;
        end else if (accept && at_window) begin
            win_last <= at_frame_end;
        end else if (win_ready) begin
            win_last <= 1'b0;
        end
    end
`endif

    // The delay line only moves on accept, which keeps win_data stable under backpressure.
    conv_line_shift #(
        .IMG_W (IMG_W)
    ) u_line (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .pixel    (pixel_in),
        .taps     (win_data)
    );

endmodule

// File: tb/tb_conv_window_buffer.sv
// tb_conv_window_buffer
// Self-checking bench for conv_window_buffer (28x28). A reference model keeps
// the current frame as a 2-D image and builds each expected window by direct
// (row, col) indexing. Define CONV_WIN_LAST_EN to also exercise win_last.
module tb_conv_window_buffer;

    localparam int W   = 28;
    localparam int H   = 28;
    localparam int WPF = (W - 4) * (H - 4);

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   pixel_in;
    logic         win_valid;
    logic         win_ready;
    logic [199:0] win_data;
`ifdef CONV_WIN_LAST_EN
    logic         win_last;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    conv_window_buffer #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pixel_in  (pixel_in),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data)
`ifdef CONV_WIN_LAST_EN
        ,
        .win_last  (win_last)
`endif
    );

    // ---------------- reference model ----------------
    logic [7:0]   img [H][W];
    int           m_row, m_col;
    int           m_accepts;
    logic         m_valid;
    logic [199:0] m_data;
`ifdef CONV_WIN_LAST_EN
    logic         m_last;
`endif
    logic         exp_ir;
    logic         ir_obs;

    function automatic logic [199:0] ref_window(input int row, input int col);
        logic [199:0] w;
        w = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                w[(r*5 + c)*8 +: 8] = img[row - 4 + r][col - 4 + c];
        return w;
    endfunction

    task automatic model_restart();
        m_row   = 0;
        m_col   = 0;
        m_valid = 1'b0;
`ifdef CONV_WIN_LAST_EN
        m_last  = 1'b0;
`endif
    endtask

    // One clock: drive inputs, sample in_ready mid-cycle, advance the model,
    // and return at posedge+1 with outputs settled.
    task automatic step(input logic v, input logic [7:0] p, input logic wr, input logic c);
        logic acc;
        in_valid  = v;
        pixel_in  = p;
        win_ready = wr;
        clr       = c;
        exp_ir    = !c && (!m_valid || wr);
        #3;
        ir_obs = in_ready;
        @(posedge clk);
        #1;
        acc = v && exp_ir;
        if (c) begin
            model_restart();
        end else if (acc) begin
            img[m_row][m_col] = p;
            m_accepts++;
            if (m_row >= 4 && m_col >= 4) begin
                m_valid = 1'b1;
                m_data  = ref_window(m_row, m_col);
`ifdef CONV_WIN_LAST_EN
                m_last  = (m_row == H - 1) && (m_col == W - 1);
`endif
            end else if (wr) begin
                m_valid = 1'b0;
`ifdef CONV_WIN_LAST_EN
                m_last  = 1'b0;
`endif
            end
            m_col++;
            if (m_col == W) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end
        end else if (wr) begin
            m_valid = 1'b0;
`ifdef CONV_WIN_LAST_EN
            m_last  = 1'b0;
`endif
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 130; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
        rst = 1'b1;
        #2;
        tests_run++; if (win_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_win_valid got %b want 0", win_valid); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests_run++; if (win_data !== 200'd0) begin tests_failed++; $display("FAIL reset_win_data got %h want 0", win_data); end
`ifdef CONV_WIN_LAST_EN
        tests_run++; if (win_last !== 1'b0) begin tests_failed++; $display("FAIL reset_win_last got %b want 0", win_last); end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_restart();
        for (int i = 0; i < 117; i++) begin
            step(1'b1, 8'($urandom), 1'b1, 1'b0);
            if (i < 116) begin
                tests_run++; if (win_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_early_window idx %0d got %b want 0", i, win_valid); end
            end else begin
                tests_run++; if (win_valid !== 1'b1) begin tests_failed++; $display("FAIL reset_first_window got %b want 1", win_valid); end
                tests_run++; if (win_data !== m_data) begin tests_failed++; $display("FAIL reset_first_data got %h want %h", win_data, m_data); end
            end
        end
    endtask

    task automatic test_frame();
        int cnt;
        cnt = 0;
        step(1'b0, 8'h00, 1'b1, 1'b1);
        for (int idx = 0; idx < W*H; idx++) begin
            step(1'b1, 8'(idx), 1'b1, 1'b0);
            if (win_valid === 1'b1) cnt++;
            tests_run++; if (ir_obs !== exp_ir) begin tests_failed++; $display("FAIL frame_in_ready idx %0d got %b want %b", idx, ir_obs, exp_ir); end
            tests_run++; if (win_valid !== m_valid) begin tests_failed++; $display("FAIL frame_win_valid idx %0d got %b want %b", idx, win_valid, m_valid); end
            if (m_valid) begin
                tests_run++; if (win_data !== m_data) begin tests_failed++; $display("FAIL frame_win_data idx %0d got %h want %h", idx, win_data, m_data); end
            end
            if (idx == 116) begin
                tests_run++;
                if (win_data[7:0] !== 8'h00 || win_data[39:32] !== 8'h04 ||
                    win_data[167:160] !== 8'h70 || win_data[199:192] !== 8'h74) begin
                    tests_failed++;
                    $display("FAIL frame_first_taps got %h %h %h %h want 00 04 70 74",
                             win_data[7:0], win_data[39:32], win_data[167:160], win_data[199:192]);
                end
            end
        end
        tests_run++; if (cnt !== WPF) begin tests_failed++; $display("FAIL frame_window_count got %0d want %0d", cnt, WPF); end
    endtask

    task automatic test_row_boundary();
        step(1'b0, 8'h00, 1'b1, 1'b1);
        for (int idx = 0; idx <= 5*W + 4; idx++) begin
            step(1'b1, 8'(idx), 1'b1, 1'b0);
            if (idx == 4*W + 27) begin
                tests_run++; if (win_valid !== 1'b1) begin tests_failed++; $display("FAIL row_end_window got %b want 1", win_valid); end
            end
            if (idx >= 5*W && idx <= 5*W + 3) begin
                tests_run++; if (win_valid !== 1'b0) begin tests_failed++; $display("FAIL row_start_no_window col %0d got %b want 0", idx - 5*W, win_valid); end
            end
            if (idx == 5*W + 4) begin
                tests_run++; if (win_valid !== 1'b1) begin tests_failed++; $display("FAIL row5_window got %b want 1", win_valid); end
                tests_run++; if (win_data[199:192] !== 8'h90) begin tests_failed++; $display("FAIL row5_tap24 got %h want 90", win_data[199:192]); end
                tests_run++; if (win_data[7:0] !== 8'h1C) begin tests_failed++; $display("FAIL row5_tap0 got %h want 1c", win_data[7:0]); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]   v44, v45;
        logic [199:0] snap;
        step(1'b0, 8'h00, 1'b1, 1'b1);
        v44 = 8'h00;
        for (int i = 0; i < 117; i++) begin
            v44 = 8'($urandom);
            step(1'b1, v44, 1'b1, 1'b0);
        end
        snap = win_data;
        tests_run++; if (win_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_first_window got %b want 1", win_valid); end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'($urandom), 1'b0, 1'b0);
            tests_run++; if (ir_obs !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, ir_obs); end
            tests_run++; if (win_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_win_valid cyc %0d got %b want 1", i, win_valid); end
            tests_run++; if (win_data !== snap) begin tests_failed++; $display("FAIL bp_hold cyc %0d got %h want %h", i, win_data, snap); end
        end
        v45 = 8'($urandom);
        step(1'b1, v45, 1'b1, 1'b0);
        tests_run++; if (win_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_next_valid got %b want 1", win_valid); end
        tests_run++; if (win_data[199:192] !== v45 || win_data[191:184] !== v44) begin
            tests_failed++; $display("FAIL bp_next_taps got %h %h want %h %h", win_data[199:192], win_data[191:184], v45, v44); end
        tests_run++; if (win_data !== m_data) begin tests_failed++; $display("FAIL bp_next_data got %h want %h", win_data, m_data); end
    endtask

    task automatic test_clr();
        int got;
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 9) < 8, 8'($urandom), $urandom_range(0, 9) < 7, 1'b0);
        step(1'b1, 8'($urandom), 1'b1, 1'b1);
        tests_run++; if (ir_obs !== 1'b0) begin tests_failed++; $display("FAIL clr_in_ready got %b want 0", ir_obs); end
        tests_run++; if (win_valid !== 1'b0) begin tests_failed++; $display("FAIL clr_win_valid got %b want 0", win_valid); end
        got = 0;
        for (int i = 0; i < 117; i++) begin
            step(1'b1, 8'($urandom), 1'b1, 1'b0);
            if (i < 116 && win_valid === 1'b1) got++;
        end
        tests_run++; if (got !== 0) begin tests_failed++; $display("FAIL clr_early_windows got %0d want 0", got); end
        tests_run++; if (win_valid !== 1'b1) begin tests_failed++; $display("FAIL clr_first_window got %b want 1", win_valid); end
        tests_run++; if (win_data !== m_data) begin tests_failed++; $display("FAIL clr_first_data got %h want %h", win_data, m_data); end
    endtask

    task automatic test_back_to_back();
        int   base, cnt, cyc, frame1_cnt;
        logic pv, wr;
        step(1'b0, 8'h00, 1'b1, 1'b1);
        base = m_accepts;
        cnt = 0;
        cyc = 0;
        frame1_cnt = -1;
        while (m_accepts - base < 2*W*H && cyc < 20000) begin
            pv = win_valid;
            wr = $urandom_range(0, 9) < 7;
            step($urandom_range(0, 9) < 8, 8'($urandom), wr, 1'b0);
            cyc++;
            if (win_valid === 1'b1 && (!pv || wr)) cnt++;
            if (frame1_cnt < 0 && m_accepts - base == W*H) frame1_cnt = cnt;
            tests_run++; if (ir_obs !== exp_ir) begin tests_failed++; $display("FAIL b2b_in_ready cyc %0d got %b want %b", cyc, ir_obs, exp_ir); end
            tests_run++; if (win_valid !== m_valid) begin tests_failed++; $display("FAIL b2b_win_valid cyc %0d got %b want %b", cyc, win_valid, m_valid); end
            if (m_valid) begin
                tests_run++; if (win_data !== m_data) begin tests_failed++; $display("FAIL b2b_win_data cyc %0d got %h want %h", cyc, win_data, m_data); end
            end
`ifdef CONV_WIN_LAST_EN
            tests_run++; if (win_last !== m_last) begin tests_failed++; $display("FAIL b2b_win_last cyc %0d got %b want %b", cyc, win_last, m_last); end
`endif
        end
        tests_run++; if (cyc >= 20000) begin tests_failed++; $display("FAIL b2b_timeout accepts %0d want %0d", m_accepts - base, 2*W*H); end
        tests_run++; if (frame1_cnt !== WPF) begin tests_failed++; $display("FAIL b2b_frame1_count got %0d want %0d", frame1_cnt, WPF); end
        tests_run++; if (cnt - frame1_cnt !== WPF) begin tests_failed++; $display("FAIL b2b_frame2_count got %0d want %0d", cnt - frame1_cnt, WPF); end
    endtask

`ifdef CONV_WIN_LAST_EN
    task automatic test_win_last();
        int lasts;
        step(1'b0, 8'h00, 1'b1, 1'b1);
        lasts = 0;
        for (int idx = 0; idx < W*H; idx++) begin
            step(1'b1, 8'($urandom), 1'b1, 1'b0);
            if (win_last === 1'b1) lasts++;
        end
        tests_run++; if (lasts !== 1) begin tests_failed++; $display("FAIL last_count got %0d want 1", lasts); end
        tests_run++; if (win_valid !== 1'b1 || win_last !== 1'b1) begin
            tests_failed++; $display("FAIL last_final got valid %b last %b want 1 1", win_valid, win_last); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'($urandom), 1'b0, 1'b0);
            tests_run++; if (win_last !== 1'b1) begin tests_failed++; $display("FAIL last_hold cyc %0d got %b want 1", i, win_last); end
            tests_run++; if (win_data !== m_data) begin tests_failed++; $display("FAIL last_data_hold cyc %0d got %h want %h", i, win_data, m_data); end
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        tests_run++; if (win_valid !== 1'b0 || win_last !== 1'b0) begin
            tests_failed++; $display("FAIL last_release got valid %b last %b want 0 0", win_valid, win_last); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        pixel_in  = 8'h00;
        win_ready = 1'b0;
        m_accepts = 0;
        m_data    = '0;
        model_restart();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_frame();
        test_row_boundary();
        test_backpressure();
        test_clr();
        test_back_to_back();
`ifdef CONV_WIN_LAST_EN
        test_win_last();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
